// File: rtl/vga_raster_gen.sv
// Raster timing engine: sync/blank generation, pixel/cell coordinates and cell-ahead tile requests.
// Optional colour-bar test pattern is enabled by defining VGA_RASTER_TESTPAT_EN.
module vga_raster_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_DISP   = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_DISP   = 480,
    parameter int V_FRONT  = 10,
    parameter int CELL     = 10,
    parameter int PIPE_LAT = 2,
    parameter int REQ_LEAD = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
`ifdef VGA_RASTER_TESTPAT_EN
    input  logic                                  i_testpat,
`endif
    input  logic [23:0]                           i_rgb,
    output logic                                  o_active,
    output logic [$clog2(H_DISP)-1:0]             o_frame_x,
    output logic [$clog2(V_DISP)-1:0]             o_frame_y,
    output logic [$clog2(H_DISP/CELL)-1:0]        o_cell_x,
    output logic [$clog2(V_DISP/CELL)-1:0]        o_cell_y,
    output logic [3:0]                            o_sub_x,
    output logic [3:0]                            o_sub_y,
    output logic                                  o_req_valid,
    output logic [$clog2(H_DISP/CELL)-1:0]        o_req_x,
    output logic [$clog2(V_DISP/CELL)-1:0]        o_req_y,
    output logic                                  o_frame_start,
    output logic                                  o_vblank,
    output logic                                  VGA_CLK,
    output logic [7:0]                            VGA_R,
    output logic [7:0]                            VGA_G,
    output logic [7:0]                            VGA_B,
    output logic                                  VGA_HS,
    output logic                                  VGA_VS,
    output logic                                  VGA_BLANK_N,
    output logic                                  VGA_SYNC_N
);
    localparam int FXW = $clog2(H_DISP);
    localparam int FYW = $clog2(V_DISP);
    localparam int CXW = $clog2(H_DISP/CELL);
    localparam int CYW = $clog2(V_DISP/CELL);

    localparam logic [10:0] H_LAST = 11'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [10:0] V_LAST = 11'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);
    localparam logic [10:0] HA     = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] HE     = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] HE_M1  = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] VA     = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] VE     = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] HS_END = 11'(H_SYNC);
    localparam logic [10:0] VS_END = 11'(V_SYNC);
    localparam logic [10:0] RQ_S   = 11'(H_SYNC + H_BACK - REQ_LEAD);
    localparam logic [10:0] RQ_E   = 11'(H_SYNC + H_BACK - REQ_LEAD + H_DISP);
    localparam logic [3:0]  SUB_LAST = 4'(CELL - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
`ifdef VGA_RASTER_TESTPAT_EN
        logic [FXW-1:0] fx;
`endif
    } sync_t;

    logic [10:0]    h_cnt, v_cnt, h_nx, v_nx;
    logic           running;
    logic [3:0]     sy, sy_nx, rsub, rsub_nx;
    logic [CYW-1:0] cy, cy_nx;
    logic [CXW-1:0] rk, rk_nx;
    logic           vact_nx, act_nx, req_nx;
    logic [FXW-1:0] fx_nx;
    sync_t          stage0, tail;
    sync_t          pipe [0:PIPE_LAT];
    logic [23:0]    pix;

    // Registers hold the current position; outputs are registered from the
    // next position so they line up with h_cnt in the same cycle.
    always_comb begin
        h_nx = 11'd0;
        v_nx = 11'd0;
        if (running) begin
            v_nx = v_cnt;
            if (h_cnt == H_LAST) begin
                v_nx = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_nx = h_cnt + 11'd1;
            end
        end
        vact_nx = (v_nx >= VA) && (v_nx < VE);
        act_nx  = vact_nx && (h_nx >= HA) && (h_nx < HE);
        fx_nx   = act_nx ? FXW'(h_nx - HA) : '0;
    end

    always_comb begin
        sy_nx = sy;
        cy_nx = cy;
        if (h_nx == 11'd0 && v_nx == 11'd0) begin
            sy_nx = '0;
            cy_nx = '0;
        end else if (running && h_cnt == HE_M1 && v_cnt >= VA && v_cnt < VE) begin
            if (sy == SUB_LAST) begin
                sy_nx = '0;
                cy_nx = cy + 1'b1;
            end else begin
                sy_nx = sy + 4'd1;
            end
        end
    end

    // Request sub-counter runs REQ_LEAD cycles ahead of the pixel sub-counter.
    always_comb begin
        rsub_nx = rsub;
        rk_nx   = rk;
        req_nx  = 1'b0;
        if (vact_nx) begin
            if (h_nx == RQ_S) begin
                rsub_nx = '0;
                rk_nx   = '0;
                req_nx  = 1'b1;
            end else if (h_nx > RQ_S && h_nx < RQ_E) begin
                if (rsub == SUB_LAST) begin
                    rsub_nx = '0;
                    rk_nx   = rk + 1'b1;
                    req_nx  = 1'b1;
                end else begin
                    rsub_nx = rsub + 4'd1;
                end
            end
        end
    end

    always_comb begin
        stage0       = '0;
        stage0.hs    = (h_nx >= HS_END);
        stage0.vs    = (v_nx >= VS_END);
        stage0.blank = act_nx;
`ifdef VGA_RASTER_TESTPAT_EN
        stage0.fx    = fx_nx;
`endif
    end

    assign tail = pipe[PIPE_LAT];

`ifdef VGA_RASTER_TESTPAT_EN
    localparam int BAR = H_DISP / 8;
    logic [2:0]  bar;
    logic [23:0] bar_rgb;
    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (tail.fx >= FXW'(i * BAR)) bar = 3'(i);
        end
        case (bar)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
        pix = i_testpat ? bar_rgb : i_rgb;
    end
`else
    assign pix = i_rgb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;  v_cnt <= '0;  running <= 1'b0;
            sy <= '0;  cy <= '0;  rsub <= '0;  rk <= '0;
            o_active <= 1'b0;  o_frame_x <= '0;  o_frame_y <= '0;
            o_cell_x <= '0;  o_cell_y <= '0;  o_sub_x <= '0;  o_sub_y <= '0;
            o_req_valid <= 1'b0;  o_req_x <= '0;  o_req_y <= '0;
            o_frame_start <= 1'b0;  o_vblank <= 1'b0;
            for (int i = 0; i <= PIPE_LAT; i++) pipe[i] <= '0;
            VGA_R <= '0;  VGA_G <= '0;  VGA_B <= '0;
            VGA_HS <= 1'b0;  VGA_VS <= 1'b0;  VGA_BLANK_N <= 1'b0;
        end else begin
            running <= 1'b1;
            h_cnt <= h_nx;  v_cnt <= v_nx;
            sy <= sy_nx;  cy <= cy_nx;  rsub <= rsub_nx;  rk <= rk_nx;

            o_active  <= act_nx;
            o_frame_x <= fx_nx;
            o_frame_y <= act_nx ? FYW'(v_nx - VA) : '0;
            o_sub_y   <= act_nx ? sy_nx : '0;
            o_cell_y  <= act_nx ? cy_nx : '0;
            if (!act_nx || h_nx == HA) begin
                o_sub_x  <= '0;
                o_cell_x <= '0;
            end else if (o_sub_x == SUB_LAST) begin
                o_sub_x  <= '0;
                o_cell_x <= o_cell_x + 1'b1;
            end else begin
                o_sub_x  <= o_sub_x + 4'd1;
            end

            o_req_valid <= req_nx;
            if (req_nx) begin
                o_req_x <= rk_nx;
                o_req_y <= cy_nx;
            end
            o_frame_start <= (h_nx == 11'd0) && (v_nx == 11'd0);
            o_vblank      <= !vact_nx;

            pipe[0] <= stage0;
            for (int i = 1; i <= PIPE_LAT; i++) pipe[i] <= pipe[i-1];

            VGA_HS      <= tail.hs;
            VGA_VS      <= tail.vs;
            VGA_BLANK_N <= tail.blank;
            VGA_R <= tail.blank ? pix[23:16] : 8'd0;
            VGA_G <= tail.blank ? pix[15:8]  : 8'd0;
            VGA_B <= tail.blank ? pix[7:0]   : 8'd0;
        end
    end

    assign VGA_CLK    = clk;
    assign VGA_SYNC_N = 1'b0;
endmodule

// File: tb/tb_vga_raster_gen.sv
// Bench for vga_raster_gen: default mode (A), CELL=8/320x240/PIPE_LAT=0 (B), tiny mode for frame wrap (C).
module tb_vga_raster_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = -1;
    int   n_chk = 0, n_fail = 0, mon_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

    // A: defaults
    logic [23:0] a_rgb = '0;
    logic a_act, a_rv, a_fs, a_vb, a_ck, a_hs, a_vs, a_bn, a_sn;
    logic [9:0] a_fx; logic [8:0] a_fy; logic [5:0] a_cx, a_cy, a_rx, a_ry;
    logic [3:0] a_sx, a_sy; logic [7:0] a_r, a_g, a_b;
    vga_raster_gen dut_a (
        .clk(clk), .rst(rst),
`ifdef VGA_RASTER_TESTPAT_EN
        .i_testpat(1'b0),
`endif
        .i_rgb(a_rgb), .o_active(a_act), .o_frame_x(a_fx), .o_frame_y(a_fy),
        .o_cell_x(a_cx), .o_cell_y(a_cy), .o_sub_x(a_sx), .o_sub_y(a_sy),
        .o_req_valid(a_rv), .o_req_x(a_rx), .o_req_y(a_ry), .o_frame_start(a_fs),
        .o_vblank(a_vb), .VGA_CLK(a_ck), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn));

    // B: 40x30 cells of 8 pixels, no renderer latency
    logic [23:0] b_rgb = 24'h123456;
    logic b_act, b_rv, b_fs, b_vb, b_ck, b_hs, b_vs, b_bn, b_sn;
    logic [8:0] b_fx; logic [7:0] b_fy; logic [5:0] b_cx, b_rx; logic [4:0] b_cy, b_ry;
    logic [3:0] b_sx, b_sy; logic [7:0] b_r, b_g, b_b;
    vga_raster_gen #(.H_DISP(320), .V_DISP(240), .CELL(8), .PIPE_LAT(0)) dut_b (
        .clk(clk), .rst(rst),
`ifdef VGA_RASTER_TESTPAT_EN
        .i_testpat(1'b1),
`endif
        .i_rgb(b_rgb), .o_active(b_act), .o_frame_x(b_fx), .o_frame_y(b_fy),
        .o_cell_x(b_cx), .o_cell_y(b_cy), .o_sub_x(b_sx), .o_sub_y(b_sy),
        .o_req_valid(b_rv), .o_req_x(b_rx), .o_req_y(b_ry), .o_frame_start(b_fs),
        .o_vblank(b_vb), .VGA_CLK(b_ck), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn));

    // C: 28 x 14 raster, 392-cycle frame
    logic c_act, c_rv, c_fs, c_vb, c_ck, c_hs, c_vs, c_bn, c_sn;
    logic [3:0] c_fx; logic [2:0] c_fy; logic [1:0] c_cx, c_rx; logic c_cy, c_ry;
    logic [3:0] c_sx, c_sy; logic [7:0] c_r, c_g, c_b;
    vga_raster_gen #(.H_SYNC(4), .H_BACK(4), .H_DISP(16), .H_FRONT(4), .V_SYNC(2), .V_BACK(2),
                     .V_DISP(8), .V_FRONT(2), .CELL(4), .PIPE_LAT(1), .REQ_LEAD(2)) dut_c (
        .clk(clk), .rst(rst),
`ifdef VGA_RASTER_TESTPAT_EN
        .i_testpat(1'b0),
`endif
        .i_rgb(24'h0), .o_active(c_act), .o_frame_x(c_fx), .o_frame_y(c_fy),
        .o_cell_x(c_cx), .o_cell_y(c_cy), .o_sub_x(c_sx), .o_sub_y(c_sy),
        .o_req_valid(c_rv), .o_req_x(c_rx), .o_req_y(c_ry), .o_frame_start(c_fs),
        .o_vblank(c_vb), .VGA_CLK(c_ck), .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b),
        .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_BLANK_N(c_bn), .VGA_SYNC_N(c_sn));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Renderer model: colour = {column, 00, AA}, two cycles behind the coordinates.
    initial begin
        logic [9:0] d1, d2;
        d1 = '0; d2 = '0;
        forever begin
            @(negedge clk);
            a_rgb = {d2[7:0], 8'h00, 8'hAA};
            d2 = d1;
            d1 = a_fx;
        end
    end

    // Running checks on A: 64 requests per active line, none in vblank, colour alignment.
    initial begin
        int reqn, ln;
        logic [9:0] h1, h2, h3;
        reqn = 0; h1 = '0; h2 = '0; h3 = '0;
        forever begin
            @(negedge clk);
            if (rst || cyc < 0) begin
                reqn = 0; h1 = '0; h2 = '0; h3 = '0;
            end else begin
                if (a_rv && a_vb) mon_err++;
                if (a_rv) reqn++;
                if (cyc % 800 == 799) begin
                    ln = (cyc / 800) % 525;
                    if (reqn != ((ln >= 35 && ln < 515) ? 64 : 0)) mon_err++;
                    reqn = 0;
                end
                if (a_bn) begin
                    if (a_r != h3[7:0] || a_g != 8'h00 || a_b != 8'hAA) mon_err++;
                end else if ({a_r, a_g, a_b} != 24'h0) mon_err++;
                h3 = h2; h2 = h1; h1 = a_fx;
            end
        end
    end

    typedef struct {
        int cyc, act, fx, fy, cx, cy, sx, sy, fs, vb, rv, rx, ry, bn, hs, vs, r;
    } vec_t;
    vec_t tbl [19];

    task automatic run_tbl(input int n);
        for (int i = 0; i < n; i++) begin
            wait_cyc(tbl[i].cyc);
            chk($sformatf("v%0d.active", i), a_act, tbl[i].act);
            chk($sformatf("v%0d.frame_x", i), a_fx, tbl[i].fx);
            chk($sformatf("v%0d.frame_y", i), a_fy, tbl[i].fy);
            chk($sformatf("v%0d.cell_x", i), a_cx, tbl[i].cx);
            chk($sformatf("v%0d.cell_y", i), a_cy, tbl[i].cy);
            chk($sformatf("v%0d.sub_x", i), a_sx, tbl[i].sx);
            chk($sformatf("v%0d.sub_y", i), a_sy, tbl[i].sy);
            chk($sformatf("v%0d.frame_start", i), a_fs, tbl[i].fs);
            chk($sformatf("v%0d.vblank", i), a_vb, tbl[i].vb);
            chk($sformatf("v%0d.req_valid", i), a_rv, tbl[i].rv);
            chk($sformatf("v%0d.req_x", i), a_rx, tbl[i].rx);
            chk($sformatf("v%0d.req_y", i), a_ry, tbl[i].ry);
            chk($sformatf("v%0d.blank_n", i), a_bn, tbl[i].bn);
            chk($sformatf("v%0d.hs", i), a_hs, tbl[i].hs);
            chk($sformatf("v%0d.vs", i), a_vs, tbl[i].vs);
            chk($sformatf("v%0d.vga_r", i), a_r, tbl[i].r);
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        //           cyc   act fx  fy cx cy sx sy fs vb rv rx ry bn hs vs r
        tbl[0]  = '{0,     0, 0,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{98,    0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{99,    0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{1602,  0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{1603,  0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[5]  = '{27999, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
        tbl[6]  = '{28000, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[7]  = '{28142, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0};
        tbl[8]  = '{28144, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[9]  = '{28147, 1, 3,  0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        tbl[10] = '{28152, 1, 8,  0, 0, 0, 8, 0, 0, 0, 1, 1, 0, 1, 1, 1, 5};
        tbl[11] = '{28154, 1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 7};
        tbl[12] = '{28772, 1, 628,0, 62,0, 8, 0, 0, 0, 1, 63,0, 1, 1, 1, 113};
        tbl[13] = '{28783, 1, 639,0, 63,0, 9, 0, 0, 0, 0, 63,0, 1, 1, 1, 124};
        tbl[14] = '{28784, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 63,0, 1, 1, 1, 125};
        tbl[15] = '{28787, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 63,0, 0, 1, 1, 0};
        tbl[16] = '{28944, 1, 0,  1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[17] = '{36142, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0};
        tbl[18] = '{36144, 1, 0,  10,0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0};

        repeat (3) @(negedge clk);
        chk("reset.vga", {a_r, a_g, a_b, a_hs, a_vs, a_bn, a_sn}, 64'h0);
        chk("reset.ctl", {a_act, a_rv, a_fs, a_vb}, 64'h0);
        rst = 1'b0;
        fork
            run_tbl(19);
            begin
                // C: frame wrap and sync widths
                wait_cyc(120); chk("c.active", c_act, 1); chk("c.frame_x", c_fx, 0);
                wait_cyc(123); chk("c.sub_x3", c_sx, 3); chk("c.cell_x0", c_cx, 0);
                wait_cyc(124); chk("c.sub_x0", c_sx, 0); chk("c.cell_x1", c_cx, 1);
                wait_cyc(391); chk("c.fs_before", c_fs, 0);
                wait_cyc(392); chk("c.fs_wrap", c_fs, 1);
                wait_cyc(393); chk("c.vs_hi", c_vs, 1);
                wait_cyc(394); chk("c.vs_lo", c_vs, 0); chk("c.hs_lo", c_hs, 0);
                wait_cyc(397); chk("c.hs_lo_end", c_hs, 0);
                wait_cyc(398); chk("c.hs_rise", c_hs, 1);
                wait_cyc(449); chk("c.vs_lo_end", c_vs, 0);
                wait_cyc(450); chk("c.vs_rise", c_vs, 1);
                wait_cyc(784); chk("c.fs_wrap2", c_fs, 1);
                // B: 8-pixel cells, BLANK_N one cycle behind o_active
                wait_cyc(16942); chk("b.req", b_rv, 1); chk("b.req_x0", b_rx, 0);
                wait_cyc(16944); chk("b.active", b_act, 1); chk("b.frame_x", b_fx, 0);
                chk("b.blank_lag", b_bn, 0);
                wait_cyc(16945); chk("b.blank_rise", b_bn, 1);
                wait_cyc(16950); chk("b.req_x1", b_rx, 1);
                wait_cyc(16951); chk("b.sub_x7", b_sx, 7); chk("b.cell_x0", b_cx, 0);
                wait_cyc(16952); chk("b.sub_x0", b_sx, 0); chk("b.cell_x1", b_cx, 1);
`ifdef VGA_RASTER_TESTPAT_EN
                wait_cyc(16985); chk("b.bar_yellow", {b_r, b_g, b_b}, 24'hFFFF00);
`else
                wait_cyc(16985); chk("b.rgb_pass", {b_r, b_g, b_b}, 24'h123456);
`endif
                wait_cyc(17263); chk("b.cell_x39", b_cx, 39); chk("b.sub_x_last", b_sx, 7);
                chk("b.frame_x_last", b_fx, 319);
                wait_cyc(17264); chk("b.active_end", b_act, 0); chk("b.blank_tail", b_bn, 1);
                wait_cyc(17265); chk("b.blank_fall", b_bn, 0); chk("b.rgb_blank", {b_r, b_g, b_b}, 0);
            end
        join

        // Mid-frame reset during an active pixel of line 45
        wait_cyc(36150);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.ctl", {a_act, a_fx, a_fy, a_cx, a_cy, a_sx, a_sy, a_rv, a_rx, a_ry, a_fs, a_vb}, 64'h0);
        chk("midrst.vga", {a_r, a_g, a_b, a_hs, a_vs, a_bn, a_sn}, 64'h0);
        rst = 1'b0;
        run_tbl(17);

        chk("monitor_errors", mon_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
